// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with single outstanding request, skid slot and redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
);

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        slot_free;
    logic        consumed;
    logic        accept;

    assign slot_free      = !instr_valid || !stall;
    assign consumed       = instr_valid && !stall;
    assign accept         = imem_req && imem_ready;
    assign imem_addr      = pc;
    assign instr_pc_plus4 = instr_pc + 32'd4;

    // State register; reset parks the unit in BOOT so the first request follows a quiet cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and request decode; redirect overrides the normal transitions
    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        case (state)
            BOOT: state_n = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_ready) state_n = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) state_n = slot_free ? REQ : HOLD;
            end
            HOLD: begin
                if (!stall) state_n = REQ;
            end
            DROP: begin
                if (imem_rvalid) state_n = REQ;
            end
            default: state_n = BOOT;
        endcase
        if (redirect_valid) begin
            // A response still owed by memory must be swallowed in DROP
            if ((state == REQ && imem_ready) ||
                (state == WAIT && !imem_rvalid) ||
                (state == DROP && !imem_rvalid)) begin
                state_n = DROP;
            end else begin
                state_n = REQ;
            end
        end
    end

    // PC, output slot and skid updates; a stalled slot never changes unless flushed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            fetch_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= 32'd0;
            skid_valid  <= 1'b0;
            skid_instr  <= NOP_INSTR;
            skid_pc     <= 32'd0;
        end else if (redirect_valid) begin
            pc          <= {redirect_pc[31:2], 2'b00};
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            skid_valid  <= 1'b0;
        end else begin
            if (consumed) begin
                instr_valid <= 1'b0;
                instr       <= NOP_INSTR;
            end
            case (state)
                REQ: begin
                    if (accept) fetch_pc <= pc;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        pc <= pc + 32'd4;
                        if (slot_free) begin
                            instr_valid <= 1'b1;
                            instr       <= imem_rdata;
                            instr_pc    <= fetch_pc;
                        end else begin
                            skid_valid <= 1'b1;
                            skid_instr <= imem_rdata;
                            skid_pc    <= fetch_pc;
                        end
                    end
                end
                HOLD: begin
                    if (!stall && skid_valid) begin
                        instr_valid <= 1'b1;
                        instr       <= skid_instr;
                        instr_pc    <= skid_pc;
                        skid_valid  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    int errors = 0;
    int checks = 0;

    logic [31:0] paddr;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    always #5 clk = ~clk;

    // Single-cycle memory: data for an accepted address returns the following cycle
    always @(posedge clk) begin
        if (rst) begin
            imem_rvalid <= 1'b0;
            paddr       <= 32'd0;
        end else begin
            imem_rvalid <= imem_req && imem_ready;
            if (imem_req && imem_ready) paddr <= imem_addr;
        end
    end
    assign imem_rdata = paddr ^ TAG;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_instr(input logic [31:0] exp_pc, input int exp_gap);
        int n;
        logic [31:0] exp_p4;
        logic [31:0] exp_word;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 20);
        exp_p4   = exp_pc + 32'd4;
        exp_word = exp_pc ^ TAG;
        chk("gap", n, exp_gap);
        chk("instr_pc", instr_pc, exp_pc);
        chk("instr", instr, exp_word);
        chk("pc_plus4", instr_pc_plus4, exp_p4);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_p4", instr_pc_plus4, 32'd4);
        chk("rst_req", {31'd0, imem_req}, 32'd0);

        rst = 1'b0;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        next_instr(32'h0, 2);
        next_instr(32'h4, 2);
        next_instr(32'h8, 2);

        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", instr_pc, 32'h8);
        end
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_instr", instr, 32'h8 ^ TAG);
        stall = 1'b0;
        next_instr(32'hC, 1);

        redirect_valid = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("drop_valid", {31'd0, instr_valid}, 32'd0);
        chk("drop_instr", instr, NOP);
        chk("drop_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("post_drop_req", {31'd0, imem_req}, 32'd1);
        chk("post_drop_addr", imem_addr, 32'h100);
        next_instr(32'h100, 2);

        stall = 1'b1;
        @(negedge clk);
        chk("wait_stall_valid", {31'd0, instr_valid}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0; stall = 1'b0;
        chk("flush_valid", {31'd0, instr_valid}, 32'd0);
        chk("flush_instr", instr, NOP);
        chk("flush_req", {31'd0, imem_req}, 32'd1);
        chk("flush_addr", imem_addr, 32'h200);
        next_instr(32'h200, 2);
        next_instr(32'h204, 2);

        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("nready_req", {31'd0, imem_req}, 32'd1);
            chk("nready_addr", imem_addr, 32'h208);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0; imem_ready = 1'b1;
        chk("nready_redir_req", {31'd0, imem_req}, 32'd1);
        chk("nready_redir_addr", imem_addr, 32'h300);
        next_instr(32'h300, 2);

        stall = 1'b1;
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_wait_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_wait_instr", instr, NOP);
        chk("async_wait_pc", instr_pc, 32'd0);
        chk("async_wait_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("restart_addr", imem_addr, 32'h0);
        next_instr(32'h0, 2);

        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold2_req", {31'd0, imem_req}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_hold_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_hold_pc", instr_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("top_req", {31'd0, imem_req}, 32'd1);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        next_instr(32'hFFFF_FFFC, 2);
        chk("wrap_addr", imem_addr, 32'h0);
        next_instr(32'h0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
